// File: rtl/head_flit_fifo_decoder.sv
// head_flit_fifo_decoder
//   Per-VC head-flit store for one router input port. A first-word-fall-through
//   FIFO holds incoming head flits. A registered decoder turns the flit at the
//   FIFO head into an output-port request for the switch allocator.
//
// Ports
//   clk                  rising-edge clock
//   rst                  asynchronous, active-low reset
//   wr_en                push headFlit into the FIFO
//   rd_en                pop the FIFO head
//   headFlit             flit to store
//   headBuffer           current FIFO head, combinational, 0 when empty
//   full                 FIFO holds HFBDepth entries
//   empty                FIFO holds no entries
//   decodeHeadFlit       request a decode of the current head
//   routeReserveRequest  decoded output-port code, held until the next decode
//   headFlitDecoded      one-cycle strobe: routeReserveRequest was just updated
module head_flit_fifo_decoder #(
  parameter int N             = 4,
  parameter int INDEX         = 1,
  parameter int DATA_WIDTH    = 8,
  parameter int HFBDepth      = 4,
  parameter int REQUEST_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [DATA_WIDTH-1:0]    headFlit,
  output logic [DATA_WIDTH-1:0]    headBuffer,
  output logic                     full,
  output logic                     empty,
  input  logic                     decodeHeadFlit,
  output logic [REQUEST_WIDTH-1:0] routeReserveRequest,
  output logic                     headFlitDecoded
);

  localparam int DW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = (HFBDepth > 1) ? $clog2(HFBDepth) : 1;
  localparam int CW = $clog2(HFBDepth + 1);

  localparam logic [DW-1:0] LOCAL_ID = DW'(INDEX);
  localparam logic [CW-1:0] DEPTH    = CW'(HFBDepth);

  typedef enum logic [1:0] {
    ROUTE_LOCAL = 2'd0,
    ROUTE_FWD   = 2'd1,
    ROUTE_BWD   = 2'd2
  } route_e;

  // FIFO state
  logic [DATA_WIDTH-1:0] mem_q [HFBDepth];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_eff, rd_eff;

  // Decoder state
  logic [REQUEST_WIDTH-1:0] req_q, req_d;
  logic                     decoded_q, decoded_d;
  logic [DW-1:0]            dest;
  route_e                   route;

  assign full  = (count_q == DEPTH);
  assign empty = (count_q == '0);

  // A write into a full FIFO is accepted only when a pop frees a slot the same edge.
  assign rd_eff = rd_en & ~empty;
  assign wr_eff = wr_en & (~full | rd_eff);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_eff) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_eff) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_eff, rd_eff})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: headBuffer is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_eff) mem_q[wr_ptr_q] <= headFlit;
  end

  always_comb begin
    headBuffer = '0;
    if (!empty) headBuffer = mem_q[rd_ptr_q];
  end

  // Route decode of the pre-pop head
  assign dest = headBuffer[DW-1:0];

  always_comb begin
    route = ROUTE_LOCAL;
    if (dest > LOCAL_ID)      route = ROUTE_FWD;
    else if (dest < LOCAL_ID) route = ROUTE_BWD;
  end

  always_comb begin
    decoded_d = decodeHeadFlit & ~empty;
    req_d     = req_q;
    if (decoded_d) req_d = REQUEST_WIDTH'(route);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q     <= '0;
      decoded_q <= 1'b0;
    end else begin
      req_q     <= req_d;
      decoded_q <= decoded_d;
    end
  end

  assign routeReserveRequest = req_q;
  assign headFlitDecoded     = decoded_q;

endmodule

// File: tb/tb_head_flit_fifo_decoder.sv
// tb_head_flit_fifo_decoder
//   Scoreboard bench for head_flit_fifo_decoder. The stimulus process keeps a
//   queue-based model of the FIFO and decoder and pushes expected per-cycle
//   state, popped flits and decode results into queues; a negedge monitor pops
//   and compares whenever the DUT presents the corresponding output.
module tb_head_flit_fifo_decoder;

  localparam int N     = 4;
  localparam int INDEX = 1;
  localparam int DW    = (N > 1) ? $clog2(N) : 1;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       decodeHeadFlit = 1'b0;
  logic [7:0] headFlit = '0;
  logic [7:0] headBuffer;
  logic       full;
  logic       empty;
  logic [1:0] routeReserveRequest;
  logic       headFlitDecoded;

  head_flit_fifo_decoder #(
    .N(N),
    .INDEX(INDEX),
    .DATA_WIDTH(8),
    .HFBDepth(DEPTH),
    .REQUEST_WIDTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .headFlit(headFlit),
    .headBuffer(headBuffer),
    .full(full),
    .empty(empty),
    .decodeHeadFlit(decodeHeadFlit),
    .routeReserveRequest(routeReserveRequest),
    .headFlitDecoded(headFlitDecoded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  bit mon_en = 1'b0;

  typedef struct {
    bit         e;
    bit         f;
    logic [7:0] head;
    logic [1:0] req;
    bit         dec;
  } st_t;

  st_t        exp_state[$];
  logic [7:0] exp_pop[$];
  logic [1:0] exp_req[$];

  // Reference model: FIFO contents as a queue, last request, strobe flag
  logic [7:0] model[$];
  logic [1:0] m_req = 2'd0;
  bit         m_dec = 1'b0;

  function automatic logic [1:0] route_of(logic [7:0] flit);
    int dest;
    dest = int'(flit) % (1 << DW);
    if (dest == INDEX) return 2'd0;
    if (dest > INDEX)  return 2'd1;
    return 2'd2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: record the expected state after the previous edge, then
  // apply the inputs and advance the model through the coming edge.
  task automatic cycle(input bit wr, input bit rd, input bit dec, input logic [7:0] d);
    st_t st;
    bit  rd_e;
    bit  wr_e;
    @(posedge clk);
    #1;
    st.e    = (model.size() == 0);
    st.f    = (model.size() == DEPTH);
    st.head = st.e ? 8'h00 : model[0];
    st.req  = m_req;
    st.dec  = m_dec;
    exp_state.push_back(st);
    mon_en = 1'b1;

    if (dec && model.size() > 0) begin
      m_req = route_of(model[0]);
      m_dec = 1'b1;
      exp_req.push_back(m_req);
    end else begin
      m_dec = 1'b0;
    end
    rd_e = rd && (model.size() > 0);
    if (rd_e) exp_pop.push_back(model[0]);
    wr_e = wr && ((model.size() < DEPTH) || rd_e);
    if (rd_e) void'(model.pop_front());
    if (wr_e) model.push_back(d);

    wr_en          = wr;
    rd_en          = rd;
    decodeHeadFlit = dec;
    headFlit       = d;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (model.size() > 0) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    end
  endtask

  // Asynchronous reset asserted in the middle of a cycle with data in the FIFO.
  task automatic mid_reset();
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_head", 32'(headBuffer), 32'h0);
    chk("rst_req", 32'(routeReserveRequest), 32'd0);
    chk("rst_dec", 32'(headFlitDecoded), 32'd0);
    exp_state.delete();
    exp_pop.delete();
    exp_req.delete();
    model.delete();
    m_req = 2'd0;
    m_dec = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_state.size() == 0) begin
        chk("state_queue_underrun", 32'd0, 32'd1);
      end else begin
        st_t s;
        s = exp_state.pop_front();
        chk("empty", 32'(empty), 32'(s.e));
        chk("full", 32'(full), 32'(s.f));
        chk("headBuffer", 32'(headBuffer), 32'(s.head));
        chk("routeReserveRequest", 32'(routeReserveRequest), 32'(s.req));
        chk("headFlitDecoded", 32'(headFlitDecoded), 32'(s.dec));
      end
      if (rd_en && !empty) begin
        if (exp_pop.size() == 0) chk("unexpected_pop", 32'(headBuffer), 32'hFFFF);
        else chk("pop_data", 32'(headBuffer), 32'(exp_pop.pop_front()));
      end
      if (headFlitDecoded) begin
        if (exp_req.size() == 0) chk("unexpected_decode", 32'(routeReserveRequest), 32'hFFFF);
        else chk("decode_req", 32'(routeReserveRequest), 32'(exp_req.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("init_empty", 32'(empty), 32'd1);
    chk("init_head", 32'(headBuffer), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Reset then idle
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);

    // Fill, overflow push dropped, drain in order
    cycle(1'b1, 1'b0, 1'b0, 8'h11);
    cycle(1'b1, 1'b0, 1'b0, 8'h22);
    cycle(1'b1, 1'b0, 1'b0, 8'h33);
    cycle(1'b1, 1'b0, 1'b0, 8'h44);
    cycle(1'b1, 1'b0, 1'b0, 8'h55);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);

    // Push+pop on empty, then push+pop on full
    cycle(1'b1, 1'b1, 1'b0, 8'hA2);
    cycle(1'b1, 1'b0, 1'b0, 8'hA3);
    cycle(1'b1, 1'b0, 1'b0, 8'hA4);
    cycle(1'b1, 1'b0, 1'b0, 8'hA5);
    cycle(1'b1, 1'b1, 1'b0, 8'hA6);
    cycle(1'b1, 1'b1, 1'b0, 8'hA7);
    drain();

    // Decode local / forward / backward
    cycle(1'b1, 1'b0, 1'b0, 8'h01);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h03);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);

    // Decode while empty: no strobe, request holds
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 0, 8'h00);

    // Held decode, then decode+pop in the same cycle uses the pre-pop head
    cycle(1'b1, 1'b0, 1'b0, 8'hF1);
    cycle(1'b1, 1'b0, 1'b0, 8'hE3);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    drain();

    // Wrap-around with interleaved push/pop pairs
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
    end

    // Partially filled FIFO, then reset mid-stream
    cycle(1'b1, 1'b0, 1'b0, 8'h77);
    cycle(1'b1, 1'b0, 1'b1, 8'h78);
    mid_reset();

    // Randomized traffic with occasional mid-stream resets
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 150; i++) begin
        cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
              $urandom_range(0, 99) < 40, 8'($urandom));
      end
      mid_reset();
    end
    for (int i = 0; i < 100; i++) begin
      cycle($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 50, 8'($urandom));
    end

    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("leftover_pops", 32'(exp_pop.size()), 32'd0);
    chk("leftover_decodes", 32'(exp_req.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
